// File: rtl/gpio_seq_ctrl.sv
// AHB-Lite master that programs the GPIO direction register once, then streams a
// small pattern table into the GPIO data register with an idle gap between writes.
module gpio_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DEPTH     = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic [15:0] dir_value,
  input  logic [15:0] interval,
  input  logic [3:0]  num_entries,
  input  logic [7:0]  loop_count,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        done,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DIR_A = 3'd1;
  localparam logic [2:0] DIR_D = 3'd2;
  localparam logic [2:0] PAT_A = 3'd3;
  localparam logic [2:0] PAT_D = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [3:0] LP_DEPTH = 4'(DEPTH);
  localparam logic [3:0] LP_LAST  = 4'(DEPTH - 1);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [15:0]   r_table [DEPTH];
  logic [IW-1:0] r_idx;
  logic [7:0]    r_pass;
  logic [15:0]   r_cnt;
  logic [15:0]   r_dir;
  logic [15:0]   r_interval;
  logic [3:0]    r_num;
  logic [7:0]    r_loops;
  logic          r_abort;
  logic          w_abort;
  logic [3:0]    w_n_last;
  logic          w_last_entry;
  logic          w_last_pass;

  // A num_entries of 0 (or one larger than the table) runs the whole table.
  always_comb begin
    w_abort      = r_abort | stop;
    w_n_last     = (r_num == 4'd0 || r_num > LP_DEPTH) ? LP_LAST : r_num - 4'd1;
    w_last_entry = (4'(r_idx) == w_n_last);
    w_last_pass  = (r_loops != 8'd0) && ((r_pass + 8'd1) == r_loops);
    w_next       = r_state;
    case (r_state)
      IDLE:  if (start) w_next = DIR_A;
      DIR_A: if (HREADY) w_next = DIR_D;
      DIR_D: if (HREADY) w_next = w_abort ? IDLE : PAT_A;
      PAT_A: if (HREADY) w_next = PAT_D;
      PAT_D: begin
        if (HREADY) begin
          if (w_abort)                         w_next = IDLE;
          else if (w_last_entry && w_last_pass) w_next = DONE;
          else if (r_interval == 16'd0)        w_next = PAT_A;
          else                                 w_next = WAIT;
        end
      end
      WAIT: begin
        if (w_abort)              w_next = IDLE;
        else if (r_cnt <= 16'd1)  w_next = PAT_A;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_pass     <= 8'd0;
      r_cnt      <= 16'd0;
      r_dir      <= 16'd0;
      r_interval <= 16'd0;
      r_num      <= 4'd0;
      r_loops    <= 8'd0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE)
        r_abort <= 1'b0;
      else if (stop && r_state != IDLE)
        r_abort <= 1'b1;
      if (r_state == IDLE && start) begin
        r_dir      <= dir_value;
        r_interval <= interval;
        r_num      <= num_entries;
        r_loops    <= loop_count;
        r_idx      <= '0;
        r_pass     <= 8'd0;
      end
      if (r_state == PAT_D && HREADY) begin
        r_cnt <= r_interval;
        if (w_last_entry) begin
          r_idx <= '0;
          if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
      if (r_state == WAIT)
        r_cnt <= r_cnt - 16'd1;
    end
  end

  // The table is writable only while idle so a running sequence sees stable data.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= 16'd0;
    end else if (r_state == IDLE && cfg_we) begin
      r_table[cfg_addr[IW-1:0]] <= cfg_wdata;
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign HTRANS = (r_state == DIR_A || r_state == PAT_A) ? 2'b10 : 2'b00;
  assign HWRITE = (r_state == DIR_A || r_state == PAT_A);
  assign HADDR  = (r_state == DIR_A) ? (BASE_ADDR + 32'd4) : BASE_ADDR;
  assign HSIZE  = 3'b010;
  assign HWDATA = (r_state == DIR_D) ? {16'h0, r_dir} :
                  (r_state == PAT_D) ? {16'h0, r_table[r_idx]} : 32'd0;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed bench for gpio_seq_ctrl: AHB write monitor, expected-write queue and
// hand-computed timing expectations for each scenario.
module tb_gpio_seq_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] dir_value;
  logic [15:0] interval;
  logic [3:0]  num_entries;
  logic [7:0]  loop_count;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;

  gpio_seq_ctrl #(.BASE_ADDR(BASE), .DEPTH(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .dir_value(dir_value), .interval(interval),
    .num_entries(num_entries), .loop_count(loop_count), .start(start),
    .stop(stop), .busy(busy), .done(done), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY)
  );

  // clock / reset / watchdog
  initial forever #5 HCLK = ~HCLK;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // HREADY generator: 0 = always ready, 1 = ~30% stalls, 2 = held low
  int hready_mode = 0;
  initial begin
    HREADY = 1'b1;
    forever begin
      @(posedge HCLK);
      #2;
      case (hready_mode)
        1:       HREADY = ($urandom_range(0, 99) >= 30);
        2:       HREADY = 1'b0;
        default: HREADY = 1'b1;
      endcase
    end
  end

  // monitor: samples on the falling edge
  logic [47:0] got_q[$];
  int          ns_q[$];
  int          cyc = 0, busy_cnt = 0, done_cnt = 0, ns_any = 0, done_cyc = 0, data_cyc = 0;
  logic        d_pend = 1'b0, st_a = 1'b0, st_d = 1'b0;
  logic [31:0] d_addr, p_addr, p_wdata;
  logic [1:0]  p_trans;
  logic        p_write;

  always @(negedge HCLK) begin
    cyc++;
    if (HRESET) begin
      d_pend = 1'b0;
      st_a   = 1'b0;
      st_d   = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (HTRANS == 2'b10) ns_any++;
      if (st_a) check("addr_hold", {29'd0, HADDR, HTRANS, HWRITE}, {29'd0, p_addr, p_trans, p_write});
      if (st_d) check("data_hold", {32'd0, HWDATA}, {32'd0, p_wdata});
      st_a    = (HTRANS == 2'b10) && !HREADY;
      st_d    = d_pend && !HREADY;
      p_addr  = HADDR;
      p_trans = HTRANS;
      p_write = HWRITE;
      p_wdata = HWDATA;
      if (d_pend && HREADY) begin
        check("hwdata_hi", {48'd0, HWDATA[31:16]}, 64'd0);
        got_q.push_back({d_addr, HWDATA[15:0]});
        data_cyc = cyc;
        d_pend   = 1'b0;
      end
      if (HTRANS == 2'b10 && HREADY) begin
        d_addr = HADDR;
        d_pend = 1'b1;
        if (HADDR == BASE) ns_q.push_back(cyc);
      end
    end
  end

  // scoreboard
  logic [47:0] exp_q[$];

  task automatic expect_write(input logic [31:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string tag, input int base);
    check({tag, "_count"}, 64'(got_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check(tag, {16'd0, got_q[base + i]}, {16'd0, exp_q[i]});
    exp_q.delete();
  endtask

  // drivers
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input logic [15:0] dv, input logic [15:0] iv, input logic [3:0] ne, input logic [7:0] lc);
    dir_value = dv; interval = iv; num_entries = ne; loop_count = lc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    check({tag, "_timeout"}, {63'd0, busy}, 64'd0);
  endtask

  int g0, b0, d0, n0, a0;

  task automatic mark();
    g0 = got_q.size(); b0 = busy_cnt; d0 = done_cnt; n0 = ns_q.size(); a0 = ns_any;
  endtask

  task automatic expect_basic();
    expect_write(BASE + 32'd4, 16'h0000);
    expect_write(BASE, 16'h0001);
    expect_write(BASE, 16'h0002);
    expect_write(BASE, 16'h0004);
  endtask

  initial begin
    HRESET = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 16'd0;
    start = 1'b0; stop = 1'b0;
    setup(16'h0, 16'h0, 4'd0, 8'd0);
    step(3);
    check("rst_htrans", {62'd0, HTRANS}, 64'd0);
    check("rst_hwrite", {63'd0, HWRITE}, 64'd0);
    check("rst_haddr",  {32'd0, HADDR}, {32'd0, BASE});
    check("rst_hwdata", {32'd0, HWDATA}, 64'd0);
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("hsize",      {61'd0, HSIZE}, 64'd2);
    HRESET = 1'b0;
    step(2);

    // basic single pass, interval 0
    cfg_write(3'd0, 16'h0001);
    cfg_write(3'd1, 16'h0002);
    cfg_write(3'd2, 16'h0004);
    setup(16'h0000, 16'd0, 4'd3, 8'd1);
    mark();
    pulse_start();
    wait_idle("s1", 100);
    expect_basic();
    check_writes("s1_wr", g0);
    check("s1_busy_cycles", 64'(busy_cnt - b0), 64'd9);
    check("s1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("s1_done_lat", 64'(done_cyc - data_cyc), 64'd1);
    for (int i = n0 + 1; i < ns_q.size(); i++)
      check("s1_gap", 64'(ns_q[i] - ns_q[i-1]), 64'd2);

    // interval 5, two passes
    setup(16'h00F0, 16'd5, 4'd3, 8'd2);
    mark();
    pulse_start();
    wait_idle("s2", 200);
    expect_write(BASE + 32'd4, 16'h00F0);
    for (int p = 0; p < 2; p++) begin
      expect_write(BASE, 16'h0001);
      expect_write(BASE, 16'h0002);
      expect_write(BASE, 16'h0004);
    end
    check_writes("s2_wr", g0);
    check("s2_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("s2_ns_cnt", 64'(ns_q.size() - n0), 64'd6);
    for (int i = n0 + 1; i < ns_q.size(); i++)
      check("s2_gap", 64'(ns_q[i] - ns_q[i-1]), 64'd7);

    // random stalls on the basic scenario
    setup(16'h0000, 16'd0, 4'd3, 8'd1);
    hready_mode = 1;
    mark();
    pulse_start();
    wait_idle("s3", 1000);
    hready_mode = 0;
    step(2);
    expect_basic();
    check_writes("s3_wr", g0);
    check("s3_done_cnt", 64'(done_cnt - d0), 64'd1);

    // stop during the first WAIT (cycle 5 after start)
    setup(16'h0000, 16'd3, 4'd3, 8'd0);
    mark();
    pulse_start();
    step(4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check("s4w_busy", {63'd0, busy}, 64'd0);
    a0 = ns_any;
    step(20);
    check("s4w_no_ns", 64'(ns_any - a0), 64'd0);
    check("s4w_done", 64'(done_cnt - d0), 64'd0);
    expect_write(BASE + 32'd4, 16'h0000);
    expect_write(BASE, 16'h0001);
    check_writes("s4w_wr", g0);

    // stop during a stalled first PAT_D (cycle 4 after start)
    mark();
    pulse_start();
    step(3);
    hready_mode = 2;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    hready_mode = 0;
    check("s4d_busy_stall", {63'd0, busy}, 64'd1);
    step(1);
    check("s4d_busy", {63'd0, busy}, 64'd0);
    a0 = ns_any;
    step(20);
    check("s4d_no_ns", 64'(ns_any - a0), 64'd0);
    check("s4d_done", 64'(done_cnt - d0), 64'd0);
    expect_write(BASE + 32'd4, 16'h0000);
    expect_write(BASE, 16'h0001);
    check_writes("s4d_wr", g0);

    // asynchronous reset during a stalled PAT_D
    setup(16'h0000, 16'd0, 4'd3, 8'd1);
    pulse_start();
    step(3);
    hready_mode = 2;
    step(1);
    check("s5_busy_pre", {63'd0, busy}, 64'd1);
    #2;
    HRESET = 1'b1;
    #1;
    check("s5_rst_htrans", {62'd0, HTRANS}, 64'd0);
    check("s5_rst_busy", {63'd0, busy}, 64'd0);
    step(2);
    HRESET = 1'b0;
    hready_mode = 0;
    step(2);
    setup(16'h0000, 16'd0, 4'd1, 8'd1);
    mark();
    pulse_start();
    wait_idle("s5", 100);
    expect_write(BASE + 32'd4, 16'h0000);
    expect_write(BASE, 16'h0000);
    check_writes("s5_wr", g0);
    check("s5_done_cnt", 64'(done_cnt - d0), 64'd1);

    // cfg_we and start while busy are ignored
    cfg_write(3'd0, 16'h0001);
    cfg_write(3'd1, 16'h0002);
    cfg_write(3'd2, 16'h0004);
    setup(16'h0000, 16'd0, 4'd3, 8'd1);
    mark();
    pulse_start();
    step(2);
    cfg_addr = 3'd0; cfg_wdata = 16'hFFFF; cfg_we = 1'b1; start = 1'b1;
    step(1);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle("s6", 100);
    step(5);
    expect_basic();
    check_writes("s6_wr", g0);
    check("s6_busy_cycles", 64'(busy_cnt - b0), 64'd9);
    check("s6_done_cnt", 64'(done_cnt - d0), 64'd1);
    mark();
    pulse_start();
    wait_idle("s6b", 100);
    expect_basic();
    check_writes("s6b_wr", g0);

    // num_entries = 0 runs the whole table
    for (int i = 0; i < 8; i++) cfg_write(3'(i), 16'h0100 + 16'(i));
    setup(16'hA5A5, 16'd1, 4'd0, 8'd1);
    mark();
    pulse_start();
    wait_idle("s7", 200);
    expect_write(BASE + 32'd4, 16'hA5A5);
    for (int i = 0; i < 8; i++) expect_write(BASE, 16'h0100 + 16'(i));
    check_writes("s7_wr", g0);
    check("s7_done_cnt", 64'(done_cnt - d0), 64'd1);
    for (int i = n0 + 1; i < ns_q.size(); i++)
      check("s7_gap", 64'(ns_q[i] - ns_q[i-1]), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
